// File: rtl/wb_stream_writer_if.sv
// Control, stream and Wishbone signals of the stream-to-Wishbone writer.
// Latency: none; this only bundles wires.
// Backpressure: s_valid/s_ready stream handshake; Wishbone cyc/stb held until ack_i or err_i.
interface wb_stream_writer_if #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 16
);
    logic               start;
    logic [31:0]        base_addr;
    logic [LEN_W-1:0]   length;
    logic               abort;
    logic               busy;
    logic               done;
    logic               error;
    logic               s_valid;
    logic [WIDTH-1:0]   s_data;
    logic               s_ready;
    logic [31:0]        adr_o;
    logic [WIDTH-1:0]   dat_o;
    logic [WIDTH/8-1:0] sel_o;
    logic               we_o;
    logic               cyc_o;
    logic               stb_o;
    logic               ack_i;
    logic               err_i;

    // The writer side: consumes control and stream, masters the bus.
    modport master (
        input  start, base_addr, length, abort, s_valid, s_data, ack_i, err_i,
        output busy, done, error, s_ready, adr_o, dat_o, sel_o, we_o, cyc_o, stb_o
    );

    // The environment side: controller, stream source and Wishbone slave.
    modport slave (
        output start, base_addr, length, abort, s_valid, s_data, ack_i, err_i,
        input  busy, done, error, s_ready, adr_o, dat_o, sel_o, we_o, cyc_o, stb_o
    );
endinterface

// File: rtl/wb_stream_writer.sv
// Writes a counted run of stream words to consecutive Wishbone addresses.
// Latency: 3 cycles per word with a slave that acks one cycle after stb.
// Backpressure: one word accepted per bus cycle; s_ready low while the bus cycle is open.
module wb_stream_writer #(
    parameter int WIDTH   = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    wb_stream_writer_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        BUS       = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam int          SEL_W    = WIDTH / 8;
    localparam logic [31:0] STEP     = 32'(SEL_W);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t             state_q;
    state_t             state_d;
    logic [31:0]        addr_q;
    logic [WIDTH-1:0]   data_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [15:0]        tmo_q;
    logic               abort_q;
    logic               error_q;

    logic               start_ok;
    logic               zero_len;
    logic               take_word;
    logic               bus_ack;
    logic               set_err;

    // Next state and one-cycle control strobes for the datapath.
    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        zero_len  = 1'b0;
        take_word = 1'b0;
        bus_ack   = 1'b0;
        set_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.length != '0) begin
                        start_ok = 1'b1;
                        state_d  = WAIT_DATA;
                    end else begin
                        zero_len = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            WAIT_DATA: begin
                // Abort wins over a waiting word so the word stays in the stream.
                if (bus.abort) begin
                    set_err = 1'b1;
                    state_d = DONE;
                end else if (bus.s_valid) begin
                    take_word = 1'b1;
                    state_d   = BUS;
                end
            end
            BUS: begin
                if (bus.err_i) begin
                    set_err = 1'b1;
                    state_d = DONE;
                end else if (bus.ack_i) begin
                    bus_ack = 1'b1;
                    // A pending abort still lets the write finish, then ends with error.
                    if (abort_q || bus.abort) begin
                        set_err = 1'b1;
                        state_d = DONE;
                    end else if (cnt_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    set_err = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and transfer datapath: address, data, count, timeout, abort and status.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            abort_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (start_ok) begin
                addr_q <= bus.base_addr;
                cnt_q  <= bus.length;
            end else if (bus_ack) begin
                addr_q <= addr_q + STEP;
                cnt_q  <= cnt_q - LEN_W'(1);
            end

            if (take_word) begin
                data_q <= bus.s_data;
            end

            // Held at zero outside BUS so every bus cycle starts a fresh count.
            if (state_q != BUS) begin
                tmo_q <= '0;
            end else if (tmo_q != TMO_LAST) begin
                tmo_q <= tmo_q + 16'd1;
            end

            // Abort during a bus cycle is remembered until that cycle terminates.
            if (state_q == BUS) begin
                abort_q <= abort_q | bus.abort;
            end else begin
                abort_q <= 1'b0;
            end

            if (start_ok || zero_len) begin
                error_q <= 1'b0;
            end else if (set_err) begin
                error_q <= 1'b1;
            end
        end
    end

    assign bus.busy    = (state_q == WAIT_DATA) || (state_q == BUS);
    assign bus.done    = (state_q == DONE);
    assign bus.error   = error_q;
    assign bus.s_ready = (state_q == WAIT_DATA) && !bus.abort;
    assign bus.cyc_o   = (state_q == BUS);
    assign bus.stb_o   = (state_q == BUS);
    assign bus.we_o    = (state_q == BUS);
    assign bus.sel_o   = (state_q == BUS) ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
    assign bus.adr_o   = addr_q;
    assign bus.dat_o   = data_q;
endmodule

// File: tb/tb_wb_stream_writer.sv
// Bench for wb_stream_writer: table of transfers plus hand-written corner sequences.
// Expected writes are queued when a transfer is set up and popped when the slave acks.
// The slave model acks or errs a programmable number of cycles after stb rises.
module tb_wb_stream_writer;
    logic clk_i;
    logic rst_ni;

    wb_stream_writer_if #(.WIDTH(32), .LEN_W(16)) bus ();

    wb_stream_writer #(.WIDTH(32), .LEN_W(16), .TIMEOUT(8)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    typedef struct {
        logic [31:0] base;
        int len;
        int nstream;
        int lat;
        int err_word;
        int mute;
        int exp_err;
        int exp_bus;
        int exp_cons;
        int exp_wr;
        int exp_run;
    } vec_t;

    int checks = 0;
    int errors = 0;

    wr_t         exp_q[$];
    logic [31:0] stream_q[$];
    int          take_cyc[$];
    int          stb_cyc[$];
    wr_t         wr_tmp;

    // Slave configuration and observed activity.
    int lat      = 1;
    int mute     = 0;
    int err_word = 0;
    int done_cnt, srdy_cnt, cyc_cnt, stb_starts, consumed, last_run;
    int cyc_no   = 0;
    int run      = 0;
    bit take     = 1'b0;
    bit prev_stb = 1'b0;
    bit err_s;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_counters();
        done_cnt = 0; srdy_cnt = 0; cyc_cnt = 0;
        stb_starts = 0; consumed = 0; last_run = 0;
        take_cyc.delete();
        stb_cyc.delete();
    endtask

    task automatic start_xfer(input logic [31:0] base, input int len);
        tick();
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.length    = 16'(len);
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(output bit err);
        bit found;
        found = 1'b0;
        err   = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk_i);
            if (bus.done) begin
                found = 1'b1;
                err   = bus.error;
            end
        end
        check("done_seen", 64'(found), 64'd1);
    endtask

    task automatic wait_stb();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk_i);
            if (bus.stb_o) found = 1'b1;
        end
        check("stb_seen", 64'(found), 64'd1);
    endtask

    // Stream source, Wishbone slave and activity monitor.
    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.ack_i   = 1'b0;
        bus.err_i   = 1'b0;
        forever begin
            @(negedge clk_i);
            take = bus.s_valid && bus.s_ready;
            if (bus.done)    done_cnt++;
            if (bus.s_ready) srdy_cnt++;
            if (bus.cyc_o)   cyc_cnt++;
            @(posedge clk_i);
            cyc_no++;
            #1;
            if (take) begin
                if (stream_q.size() > 0) void'(stream_q.pop_front());
                consumed++;
                take_cyc.push_back(cyc_no - 1);
            end
            if (stream_q.size() > 0) begin
                bus.s_valid = 1'b1;
                bus.s_data  = stream_q[0];
            end else begin
                bus.s_valid = 1'b0;
            end
            bus.ack_i = 1'b0;
            bus.err_i = 1'b0;
            if (bus.stb_o) begin
                if (!prev_stb) begin
                    stb_starts++;
                    stb_cyc.push_back(cyc_no);
                    run = 0;
                end
                run++;
                last_run = run;
                if (mute == 0 && run > lat) begin
                    if (stb_starts == err_word) begin
                        bus.err_i = 1'b1;
                    end else begin
                        bus.ack_i = 1'b1;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_write: got adr 0x%0h, required no write", bus.adr_o);
                        end else begin
                            wr_t e;
                            e = exp_q.pop_front();
                            check("wr_adr", 64'(bus.adr_o), 64'(e.adr));
                            check("wr_dat", 64'(bus.dat_o), 64'(e.dat));
                            check("wr_sel_we_cyc", 64'({bus.sel_o, bus.we_o, bus.cyc_o}), 64'({4'hF, 1'b1, 1'b1}));
                        end
                    end
                end
            end
            prev_stb = bus.stb_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            base          len ns lat ew mu err bus cons wr run
        vecs[0] = '{32'h0000_0100, 4, 4, 1, 0, 0, 0, 4, 4, 4, 2};
        vecs[1] = '{32'hFFFF_FFFC, 2, 2, 1, 0, 0, 0, 2, 2, 2, 2};
        vecs[2] = '{32'h0000_0200, 3, 3, 1, 2, 0, 1, 2, 2, 1, 2};
        vecs[3] = '{32'h0000_0300, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
        vecs[4] = '{32'h0000_0400, 2, 2, 1, 0, 1, 1, 1, 1, 0, 8};
        vecs[5] = '{32'h0000_0500, 3, 3, 3, 0, 0, 0, 3, 3, 3, 4};
        vecs[6] = '{32'h0000_0600, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};

        rst_ni        = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.abort     = 1'b0;
        clear_counters();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ctrl", 64'({bus.busy, bus.done, bus.error, bus.s_ready, bus.cyc_o, bus.stb_o, bus.we_o}), 64'd0);
        check("rst_adr", 64'(bus.adr_o), 64'd0);
        check("rst_dat", 64'(bus.dat_o), 64'd0);
        check("rst_sel", 64'(bus.sel_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            clear_counters();
            lat      = vecs[v].lat;
            mute     = vecs[v].mute;
            err_word = vecs[v].err_word;
            for (int i = 0; i < vecs[v].nstream; i++)
                stream_q.push_back(32'h0000_00A0 + 32'(v * 256 + i));
            for (int i = 0; i < vecs[v].exp_wr; i++) begin
                wr_tmp.adr = vecs[v].base + 32'(4 * i);
                wr_tmp.dat = 32'h0000_00A0 + 32'(v * 256 + i);
                exp_q.push_back(wr_tmp);
            end
            start_xfer(vecs[v].base, vecs[v].len);
            wait_done(err_s);
            check("vec_error", 64'(err_s), 64'(vecs[v].exp_err));
            tick();
            tick();
            @(negedge clk_i);
            check("vec_done_once", 64'(done_cnt), 64'd1);
            check("vec_error_held", 64'(bus.error), 64'(vecs[v].exp_err));
            check("vec_bus_cycles", 64'(stb_starts), 64'(vecs[v].exp_bus));
            check("vec_consumed", 64'(consumed), 64'(vecs[v].exp_cons));
            check("vec_last_stb_len", 64'(last_run), 64'(vecs[v].exp_run));
            check("vec_writes_left", 64'(exp_q.size()), 64'd0);
            if (v == 0) begin
                check("lat_word_period", 64'(take_cyc[1] - take_cyc[0]), 64'd3);
                check("lat_take_to_stb", 64'(stb_cyc[0] - take_cyc[0]), 64'd1);
            end
            exp_q.delete();
            stream_q.delete();
        end

        // Zero-length start: done in the cycle after start is sampled, no bus activity.
        clear_counters();
        lat = 1; mute = 0; err_word = 0;
        tick();
        bus.start  = 1'b1;
        bus.length = '0;
        @(negedge clk_i);
        check("len0_no_early_done", 64'(bus.done), 64'd0);
        tick();
        bus.start = 1'b0;
        @(negedge clk_i);
        check("len0_done", 64'({bus.done, bus.busy, bus.error}), 64'b100);
        tick();
        @(negedge clk_i);
        check("len0_done_drop", 64'(bus.done), 64'd0);
        check("len0_no_cyc", 64'(cyc_cnt), 64'd0);

        // Abort mid bus cycle; the write still completes three cycles later.
        clear_counters();
        lat = 4;
        for (int i = 0; i < 3; i++) stream_q.push_back(32'h0000_00B0 + 32'(i));
        wr_tmp.adr = 32'h0000_0700;
        wr_tmp.dat = 32'h0000_00B0;
        exp_q.push_back(wr_tmp);
        start_xfer(32'h0000_0700, 3);
        wait_stb();
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        srdy_cnt  = 0;
        wait_done(err_s);
        check("abort_error", 64'(err_s), 64'd1);
        check("abort_no_sready", 64'(srdy_cnt), 64'd0);
        check("abort_bus_cycles", 64'(stb_starts), 64'd1);
        check("abort_consumed", 64'(consumed), 64'd1);
        check("abort_ack_run", 64'(last_run), 64'd5);
        check("abort_writes_left", 64'(exp_q.size()), 64'd0);
        stream_q.delete();
        exp_q.delete();
        tick();

        // Reset in the middle of a bus cycle: bus drops, no done pulse.
        clear_counters();
        lat = 1; mute = 1;
        stream_q.push_back(32'h0000_00C0);
        stream_q.push_back(32'h0000_00C1);
        start_xfer(32'h0000_0800, 2);
        wait_stb();
        tick();
        rst_ni = 1'b0;
        tick();
        @(negedge clk_i);
        check("midrst_bus_drop", 64'({bus.cyc_o, bus.stb_o, bus.busy}), 64'd0);
        check("midrst_adr_dat", 64'({bus.adr_o, bus.dat_o}), 64'd0);
        stream_q.delete();
        tick();
        rst_ni = 1'b1;
        repeat (4) tick();
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        mute = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
